// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and pixel normaliser for the MNIST frame streamer.
package mnist_pkg;

   localparam int unsigned NUM_PIXELS = 784;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned ADDR_W     = 10;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      WAIT   = 2'd3
   } fs_state_t;

   // Maps 0..255 onto 0..1.0 in Q8.8; the MSB correction makes 255 land exactly on 1.0.
   function automatic logic [DATA_W-1:0] norm(input logic [PIX_W-1:0] p);
      logic [PIX_W:0] w_sum;
      w_sum = {1'b0, p} + {{PIX_W{1'b0}}, p[PIX_W-1]};
      return {{(DATA_W-PIX_W-1){1'b0}}, w_sum};
   endfunction

endpackage

// File: rtl/mnist_frame_streamer_if.sv
// Pixel-input, inference-core and result signals of the frame streamer.
interface mnist_frame_streamer_if;
   import mnist_pkg::*;

   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_ready;
   logic              frame_abort;
   logic              nn_inp_rdy;
   logic [DATA_W-1:0] nn_inp_data;
   logic              nn_all_ready;
   logic [3:0]        nn_digit;
   logic [7:0]        nn_conf;
   logic              result_valid;
   logic [3:0]        result_digit;
   logic [7:0]        result_conf;
   logic              busy;
   logic              timeout_err;

   modport slave (
      input  pix_valid, pix_data, frame_abort, nn_all_ready, nn_digit, nn_conf,
      output pix_ready, nn_inp_rdy, nn_inp_data, result_valid, result_digit,
             result_conf, busy, timeout_err
   );

   modport master (
      output pix_valid, pix_data, frame_abort, nn_all_ready, nn_digit, nn_conf,
      input  pix_ready, nn_inp_rdy, nn_inp_data, result_valid, result_digit,
             result_conf, busy, timeout_err
   );

endinterface

// File: rtl/mnist_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with registered output.
module mnist_frame_ram
   import mnist_pkg::*;
#(
   parameter int unsigned DEPTH = NUM_PIXELS,
   parameter int unsigned WIDTH = PIX_W,
   parameter int unsigned AW    = ADDR_W
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Write port; contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read port with one cycle of latency.
   always_ff @(posedge clk) begin
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mnist_frame_streamer.sv
// Buffers one 28x28 frame, replays it normalised as a gap-free burst and captures the prediction.
module mnist_frame_streamer
   import mnist_pkg::*;
#(
   parameter int unsigned RESULT_TIMEOUT = 64
) (
   input logic                   clk,
   input logic                   reset,
   mnist_frame_streamer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(RESULT_TIMEOUT + 1);

   fs_state_t         r_state;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_pix_ready;
   logic              r_nn_inp_rdy;
   logic              r_result_valid;
   logic              r_timeout_err;
   logic [3:0]        r_result_digit;
   logic [7:0]        r_result_conf;

   logic              w_accept;
   logic              w_rd_en;
   logic [PIX_W-1:0]  w_rd_data;

   // The accept is suppressed while an abort is pending so the discarded frame cannot leak a write.
   assign w_accept = (r_state == FILL) && r_pix_ready && bus.pix_valid && !bus.frame_abort;

   // r_rd_addr runs one ahead of the beat being presented; it reaches NUM_PIXELS on the last beat.
   assign w_rd_en  = (r_state == PRIME) ||
                     ((r_state == STREAM) && (r_rd_addr < ADDR_W'(NUM_PIXELS)));

   mnist_frame_ram #(
      .DEPTH (NUM_PIXELS),
      .WIDTH (PIX_W),
      .AW    (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_accept),
      .i_wr_addr (r_wr_addr),
      .i_wr_data (bus.pix_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Frame sequencer: fill, prime the RAM read, stream, then wait for the prediction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= FILL;
         r_wr_addr      <= '0;
         r_rd_addr      <= '0;
         r_wait_cnt     <= '0;
         r_pix_ready    <= 1'b1;
         r_nn_inp_rdy   <= 1'b0;
         r_result_valid <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_result_digit <= '0;
         r_result_conf  <= '0;
      end else begin
         r_result_valid <= 1'b0;
         r_timeout_err  <= 1'b0;
         if (bus.frame_abort) begin
            r_state      <= FILL;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wait_cnt   <= '0;
            r_pix_ready  <= 1'b1;
            r_nn_inp_rdy <= 1'b0;
         end else begin
            case (r_state)
               FILL: begin
                  if (w_accept) begin
                     if (r_wr_addr == ADDR_W'(NUM_PIXELS - 1)) begin
                        r_wr_addr   <= '0;
                        r_pix_ready <= 1'b0;
                        r_state     <= PRIME;
                     end else begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                     end
                  end
               end
               PRIME: begin
                  r_rd_addr    <= ADDR_W'(1);
                  r_nn_inp_rdy <= 1'b1;
                  r_state      <= STREAM;
               end
               STREAM: begin
                  if (r_rd_addr == ADDR_W'(NUM_PIXELS)) begin
                     r_nn_inp_rdy <= 1'b0;
                     r_rd_addr    <= '0;
                     r_wait_cnt   <= '0;
                     r_state      <= WAIT;
                  end else begin
                     r_rd_addr <= r_rd_addr + ADDR_W'(1);
                  end
               end
               WAIT: begin
                  if (bus.nn_all_ready) begin
                     r_result_digit <= bus.nn_digit;
                     r_result_conf  <= bus.nn_conf;
                     r_result_valid <= 1'b1;
                     r_pix_ready    <= 1'b1;
                     r_state        <= FILL;
                  end else if (r_wait_cnt == CNT_W'(RESULT_TIMEOUT - 1)) begin
                     r_timeout_err <= 1'b1;
                     r_pix_ready   <= 1'b1;
                     r_state       <= FILL;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                  end
               end
               default: r_state <= FILL;
            endcase
         end
      end
   end

   assign bus.pix_ready    = r_pix_ready;
   assign bus.nn_inp_rdy   = r_nn_inp_rdy;
   // Normalising straight off the RAM output register keeps the first beat two cycles after the last accept.
   assign bus.nn_inp_data  = r_nn_inp_rdy ? norm(w_rd_data) : '0;
   assign bus.result_valid = r_result_valid;
   assign bus.result_digit = r_result_digit;
   assign bus.result_conf  = r_result_conf;
   assign bus.timeout_err  = r_timeout_err;
   assign bus.busy         = (r_state != FILL);

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Directed bench for mnist_frame_streamer with a scoreboard of expected burst beats.
module tb_mnist_frame_streamer;

   localparam int TO = 64;
   localparam int NP = 784;

   logic clk;
   logic reset;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic [15:0] sb [$];

   mnist_frame_streamer_if bus ();

   mnist_frame_streamer #(
      .RESULT_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] tb_norm(input logic [7:0] p);
      return 16'(p) + ((p >= 8'd128) ? 16'd1 : 16'd0);
   endfunction

   function automatic logic [7:0] pix_of(input int kind, input int i);
      case (kind)
         0:       return 8'(i % 256);
         1:       return 8'hFF;
         default: return 8'((i + 100) % 256);
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pix_ready"}, bus.pix_ready, 1);
      chk({tag, "_inp_rdy"}, bus.nn_inp_rdy, 0);
      chk({tag, "_inp_data"}, bus.nn_inp_data, 0);
      chk({tag, "_rv"}, bus.result_valid, 0);
      chk({tag, "_digit"}, bus.result_digit, 0);
      chk({tag, "_conf"}, bus.result_conf, 0);
      chk({tag, "_timeout"}, bus.timeout_err, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   // Returns just after the edge that performs the final accept.
   task automatic send_frame(input int kind, input int gap_pct, input int n_pix, output int acc_edge);
      int i;
      int guard;
      logic [7:0] p;
      i = 0;
      guard = 0;
      while (i < n_pix && guard < 20000) begin
         @(posedge clk); #1;
         p = pix_of(kind, i);
         bus.pix_valid = ($urandom_range(99) >= gap_pct);
         bus.pix_data  = p;
         @(negedge clk);
         if (bus.pix_valid && bus.pix_ready) begin
            sb.push_back(tb_norm(p));
            i++;
         end
         guard++;
      end
      if (i < n_pix) chk("fill_accepts", i, n_pix);
      @(posedge clk); #1;
      acc_edge = cyc;
      bus.pix_valid = 1'b0;
   endtask

   // Returns at the negedge of the first WAIT cycle (or after a mid-burst reset).
   task automatic check_burst(input int acc_edge, input int kind, input int reset_at);
      int beats;
      int guard;
      logic [15:0] e;
      @(negedge clk);
      chk("prime_pix_ready", bus.pix_ready, 0);
      chk("prime_inp_rdy", bus.nn_inp_rdy, 0);
      chk("prime_busy", bus.busy, 1);
      @(negedge clk);
      guard = 0;
      while (!bus.nn_inp_rdy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("burst_start_edge", cyc, acc_edge + 1);
      beats = 0;
      while (bus.nn_inp_rdy && beats < 2000) begin
         if (beats == reset_at) begin
            reset = 1'b1;
            #1;
            chk_reset_vals("rst_async");
            @(negedge clk);
            chk_reset_vals("rst_held");
            reset = 1'b0;
            sb.delete();
            return;
         end
         if (sb.size() == 0) begin
            chk("sb_level", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("beat", bus.nn_inp_data, e);
         end
         if (kind == 0 && beats == 128) chk("beat128", bus.nn_inp_data, 16'h0081);
         if (kind == 0 && beats == 255) chk("beat255", bus.nn_inp_data, 16'h0100);
         if (kind == 0 && beats == 256) chk("beat256", bus.nn_inp_data, 16'h0000);
         if (kind == 1) chk("beat_ff", bus.nn_inp_data, 16'h0100);
         beats++;
         @(negedge clk);
      end
      chk("burst_len", beats, NP);
      chk("sb_empty", sb.size(), 0);
      chk("post_burst_data", bus.nn_inp_data, 0);
      chk("wait_busy", bus.busy, 1);
   endtask

   // Drives a prediction into WAIT and expects exactly one result pulse.
   task automatic deliver_result(input int delay, input logic [3:0] d, input logic [7:0] c);
      int n;
      repeat (delay) @(posedge clk);
      #1;
      bus.nn_all_ready = 1'b1;
      bus.nn_digit     = d;
      bus.nn_conf      = c;
      n = 0;
      while (!bus.result_valid && !bus.timeout_err && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rv_latency", n, 2);
      chk("rv_pulse", bus.result_valid, 1);
      chk("rv_no_timeout", bus.timeout_err, 0);
      chk("res_digit", bus.result_digit, d);
      chk("res_conf", bus.result_conf, c);
      @(posedge clk); #1;
      bus.nn_all_ready = 1'b0;
      bus.nn_digit     = ~d;
      bus.nn_conf      = ~c;
      @(negedge clk);
      chk("rv_one_cycle", bus.result_valid, 0);
      chk("res_busy", bus.busy, 0);
      chk("res_pix_ready", bus.pix_ready, 1);
   endtask

   initial begin
      int acc;
      int n;
      logic saw_rv;
      reset            = 1'b1;
      bus.pix_valid    = 1'b0;
      bus.pix_data     = '0;
      bus.frame_abort  = 1'b0;
      bus.nn_all_ready = 1'b0;
      bus.nn_digit     = '0;
      bus.nn_conf      = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("post_reset");

      // Ramp frame without gaps, then a prediction 5 cycles after the burst.
      send_frame(0, 0, NP, acc);
      check_burst(acc, 0, -1);
      deliver_result(4, 4'd7, 8'hD2);

      // All-0xFF frame with 50% valid gaps; result must hold through FILL; then timeout.
      chk("hold_digit_fill", bus.result_digit, 7);
      send_frame(1, 50, NP, acc);
      chk("hold_conf_fill", bus.result_conf, 8'hD2);
      check_burst(acc, 1, -1);
      chk("hold_digit_wait", bus.result_digit, 7);
      n = 0;
      saw_rv = 1'b0;
      while (!bus.timeout_err && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.result_valid) saw_rv = 1'b1;
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_pulse", bus.timeout_err, 1);
      chk("timeout_no_rv", saw_rv, 0);
      chk("timeout_digit", bus.result_digit, 7);
      chk("timeout_conf", bus.result_conf, 8'hD2);
      @(negedge clk);
      chk("timeout_one_cycle", bus.timeout_err, 0);
      chk("timeout_pix_ready", bus.pix_ready, 1);
      chk("timeout_busy", bus.busy, 0);

      // Abort after 400 pixels, with a pixel offered in the abort cycle, then a fresh frame.
      send_frame(0, 0, 400, acc);
      bus.frame_abort = 1'b1;
      bus.pix_valid   = 1'b1;
      bus.pix_data    = 8'hAA;
      @(negedge clk);
      chk("abort_pix_ready", bus.pix_ready, 1);
      @(posedge clk); #1;
      bus.frame_abort = 1'b0;
      bus.pix_valid   = 1'b0;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_inp_rdy", bus.nn_inp_rdy, 0);
      chk("abort_rv", bus.result_valid, 0);
      sb.delete();
      send_frame(2, 0, NP, acc);
      check_burst(acc, 2, -1);
      deliver_result(1, 4'd2, 8'h40);

      // Async reset at burst beat 300, then a full frame must stream correctly.
      send_frame(0, 0, NP, acc);
      check_burst(acc, 0, 300);
      send_frame(2, 25, NP, acc);
      check_burst(acc, 2, -1);
      deliver_result(2, 4'd9, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
